ask_demod_rx: RTL and testbench
===============================

// Module: ask_demod_rx
// PURPOSE
//  Receive end of the modulation path: accepts signed 16-bit sample points
//  (the data_pt stream produced on the transmit side), recovers binary-ASK
//  bits by integrate-and-dump over SPB samples, and buffers recovered bits in
//  a 1-bit-wide FIFO that downstream logic drains with rEN.
// PARAMETERS
//  SPB    8          samples per bit, power of 2, 2..64
//  DEPTH  8          recovered-bit FIFO depth, power of 2, 2..64
//  THRESH 21'd65536  energy threshold; bit=1 when sum|s| >= THRESH
// PORTS
//  CLK       in   1   clock, all state on rising edge
//  RESET     in   1   asynchronous, active-low reset
//  sValid    in   1   data_pt carries a valid sample this cycle
//  data_pt   in   16  sample, signed two's complement
//  sync      in   1   bit-boundary marker, qualified by sValid
//  rEN       in   1   pop one recovered bit
//  dOut      out  1   last popped bit (registered)
//  bEmpty    out  1   FIFO empty
//  bFull     out  1   FIFO full
//  bitRdy    out  1   one-cycle pulse: a bit was decided
//  overflow  out  1   sticky: a decided bit was dropped because FIFO was full
// BEHAVIOUR
//  Reset (RESET=0, async): FSM=IDLE, acc=0, cnt=0, FIFO pointers=0;
//   dOut=0, bEmpty=1, bFull=0, bitRdy=0, overflow=0. Mid-operation reset
//   discards partial accumulation and all buffered bits.
//  |s|: 17-bit unsigned; -32768 -> 32768 (no saturation). acc is
//   17+log2(SPB) bits wide and cannot overflow.
//  FSM:
//   IDLE: samples ignored. sValid&&sync -> ACC with acc=|s|, cnt=1.
//   ACC : sValid&&sync -> restart (acc=|s|, cnt=1), partial bit discarded.
//         sValid&&!sync -> acc+=|s|, cnt+=1. When the SPB-th sample arrives
//         (cnt==SPB-1 on entry): bit=(acc+|s| >= THRESH); push bit; acc=0,
//         cnt=0; stay in ACC (next SPB samples form the next bit, no sync
//         needed).
//         !sValid -> hold acc/cnt (gaps allowed, no timeout).
//  Decision latency: bitRdy high and FIFO written on the edge after the
//   cycle carrying the SPB-th sample; bEmpty falls on that same edge.
//  Push when full: bit dropped, overflow set (held until reset), bitRdy still
//   pulses. If rEN&&!bEmpty in the same cycle, the pop frees a slot and the
//   push is accepted (no overflow).
//  Pop: rEN&&!bEmpty -> dOut loads FIFO head on that edge, read pointer
//   advances. rEN while empty: ignored, dOut holds.
//  Simultaneous push+pop when not full/empty: count unchanged, both occur.
//  Pointers: log2(DEPTH)+1 bits, wrap-around modulo 2*DEPTH; full = MSBs
//   differ and LSBs equal; empty = pointers equal.
// TESTING
//  1 Reset mid-stream with RESET=0 -> dOut=0,bEmpty=1,bFull=0,overflow=0
//    immediately (async), before any CLK edge.
//  2 sync + 8 samples alternating +16000/-16000 (sum 128000) -> bit 1; next
//    8 samples of +100 (sum 800) -> bit 0; two rEN pops -> dOut 1 then 0.
//  3 sync + 8 samples of -32768 (sum 262144) -> bit 1, no wrap; 8 samples of
//    +8192 (sum 65536 = THRESH) -> bit 1 (boundary is >=).
//  4 Decide 8 bits without reading -> bFull=1; 9th bit -> overflow=1,
//    bitRdy pulses; 8 pops return first 8 bits in order, bEmpty=1 after.
//  5 Full FIFO, 9th decision coinciding with rEN -> overflow stays 0,
//    bFull stays 1, dOut = oldest bit.
//  6 sync, 5 samples, sync again, 8 samples of +16000 with sValid gaps ->
//    exactly one bit (1); partial 5-sample group produces no bitRdy.

Source files
------------

// File: rtl/ask_demod_rx_if.sv
// Sample-in / recovered-bit-out bundle for the ASK receiver.
// master drives samples and pops; slave (the receiver) drives the FIFO status.
interface ask_demod_rx_if;
    logic        sValid;
    logic [15:0] data_pt;
    logic        sync;
    logic        rEN;
    logic        dOut;
    logic        bEmpty;
    logic        bFull;
    logic        bitRdy;
    logic        overflow;

    modport master (
        output sValid, data_pt, sync, rEN,
        input  dOut, bEmpty, bFull, bitRdy, overflow
    );

    modport slave (
        input  sValid, data_pt, sync, rEN,
        output dOut, bEmpty, bFull, bitRdy, overflow
    );
endinterface

// File: rtl/ask_demod_rx.sv
// Binary-ASK receiver: integrate-and-dump |sample| over SPB samples, threshold, buffer bits in a FIFO.
// Latency: bit decided and written on the edge after the SPB-th sample; full FIFO drops bits (sticky overflow) unless popped same cycle.
module ask_demod_rx #(
    parameter int          SPB    = 8,
    parameter int          DEPTH  = 8,
    parameter logic [20:0] THRESH = 21'd65536
) (
    input  logic           CLK,
    input  logic           RESET,
    ask_demod_rx_if.slave  bus
);
    localparam int CW = $clog2(SPB);
    localparam int AW = 17 + CW;
    localparam int AB = $clog2(DEPTH);
    localparam int PW = AB + 1;
    localparam int MW = (AW > 21) ? AW : 21;

    typedef enum logic {IDLE, ACC} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0] mem_q;
    logic            dout_q, dout_d;
    logic            bitrdy_q, bitrdy_d;
    logic            ovf_q, ovf_d;

    logic signed [16:0] s_ext;
    logic [16:0]     abs_s;
    logic [AW-1:0]   abs_ext;
    logic [AW-1:0]   sum;
    logic [MW-1:0]   sum_cmp;
    logic [MW-1:0]   thr_cmp;
    logic            decide;
    logic            bit_val;
    logic            empty;
    logic            full;
    logic            pop;
    logic            push;

    // 17-bit magnitude so that -32768 maps to +32768 without saturating.
    always_comb begin
        s_ext   = {bus.data_pt[15], bus.data_pt};
        abs_s   = s_ext[16] ? 17'(-s_ext) : 17'(s_ext);
        abs_ext = {{CW{1'b0}}, abs_s};
        sum     = acc_q + abs_ext;
        sum_cmp = MW'(sum);
        thr_cmp = MW'(THRESH);
        bit_val = (sum_cmp >= thr_cmp);
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        decide  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.sValid && bus.sync) begin
                    state_d = ACC;
                    acc_d   = abs_ext;
                    cnt_d   = CW'(1);
                end
            end
            ACC: begin
                if (bus.sValid) begin
                    if (bus.sync) begin
                        acc_d = abs_ext;
                        cnt_d = CW'(1);
                    end else if (cnt_q == CW'(SPB - 1)) begin
                        decide = 1'b1;
                        acc_d  = '0;
                        cnt_d  = '0;
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[AB-1:0] == rd_ptr_q[AB-1:0]);
        pop      = bus.rEN && !empty;
        // A same-cycle pop frees the slot the push needs.
        push     = decide && (!full || pop);
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        dout_d   = pop  ? mem_q[rd_ptr_q[AB-1:0]] : dout_q;
        bitrdy_d = decide;
        ovf_d    = ovf_q | (decide && full && !pop);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            dout_q   <= 1'b0;
            bitrdy_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            dout_q   <= dout_d;
            bitrdy_q <= bitrdy_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q[AB-1:0]] <= bit_val;
        end
    end

    assign bus.dOut     = dout_q;
    assign bus.bEmpty   = empty;
    assign bus.bFull    = full;
    assign bus.bitRdy   = bitrdy_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_ask_demod_rx.sv
// Bench for ask_demod_rx: directed and random sample streams against a queue-based reference model.
module tb_ask_demod_rx;
    localparam int SPB    = 8;
    localparam int DEPTH  = 8;
    localparam int THRESH = 65536;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;
    always #5 CLK = ~CLK;

    ask_demod_rx_if bus();

    ask_demod_rx #(.SPB(SPB), .DEPTH(DEPTH), .THRESH(21'd65536)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit m_run;
    int m_sum;
    int m_n;
    bit mq[$];
    bit m_dout;
    bit m_ovf;
    bit exp_rdy_q[$];
    bit exp_dout_q[$];
    bit chk_en = 1'b0;
    bit mon_e;

    task automatic chk(string name, logic [31:0] act, int exp);
        total++;
        if (act !== 32'(exp)) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0;
        m_sum = 0;
        m_n   = 0;
        mq.delete();
        m_dout = 1'b0;
        m_ovf  = 1'b0;
        exp_rdy_q.delete();
        exp_dout_q.delete();
    endtask

    task automatic step(bit v, int s, bit sy, bit r);
        int a;
        bit dec;
        bit b;
        bus.sValid  = v;
        bus.data_pt = 16'(s);
        bus.sync    = sy;
        bus.rEN     = r;
        @(posedge CLK);
        #1;
        a   = (s < 0) ? -s : s;
        dec = 1'b0;
        b   = 1'b0;
        if (v) begin
            if (sy) begin
                m_run = 1'b1;
                m_sum = a;
                m_n   = 1;
            end else if (m_run) begin
                m_sum += a;
                m_n++;
                if (m_n == SPB) begin
                    dec   = 1'b1;
                    b     = (m_sum >= THRESH);
                    m_sum = 0;
                    m_n   = 0;
                end
            end
        end
        if (r && mq.size() > 0) begin
            m_dout = mq.pop_front();
            exp_dout_q.push_back(m_dout);
        end
        if (dec) begin
            exp_rdy_q.push_back(b);
            if (mq.size() < DEPTH) mq.push_back(b);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic pops(int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b1);
    endtask

    // One bit's worth of samples with alternating sign.
    task automatic group(int amp, bit first_sync, bit pop_last);
        for (int i = 0; i < SPB; i++)
            step(1'b1, (i % 2) ? -amp : amp, first_sync && (i == 0), pop_last && (i == SPB - 1));
    endtask

    task automatic do_reset(string tag);
        bus.sValid  = 1'b0;
        bus.data_pt = '0;
        bus.sync    = 1'b0;
        bus.rEN     = 1'b0;
        #2;
        RESET = 1'b0;
        model_reset();
        #1;
        chk({tag, "_dOut"},     bus.dOut,     0);
        chk({tag, "_bEmpty"},   bus.bEmpty,   1);
        chk({tag, "_bFull"},    bus.bFull,    0);
        chk({tag, "_overflow"}, bus.overflow, 0);
        chk({tag, "_bitRdy"},   bus.bitRdy,   0);
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b1;
    endtask

    always @(negedge CLK) begin
        if (RESET && chk_en) begin
            chk("bitRdy", bus.bitRdy, int'(exp_rdy_q.size() > 0));
            if (exp_rdy_q.size() > 0) mon_e = exp_rdy_q.pop_front();
            if (exp_dout_q.size() > 0) begin
                mon_e = exp_dout_q.pop_front();
                chk("dOut_pop", bus.dOut, int'(mon_e));
            end
            chk("dOut_hold", bus.dOut,     int'(m_dout));
            chk("bEmpty",    bus.bEmpty,   int'(mq.size() == 0));
            chk("bFull",     bus.bFull,    int'(mq.size() == DEPTH));
            chk("overflow",  bus.overflow, int'(m_ovf));
        end
    end

    initial begin
        bit [7:0] pat;
        int amp;
        int s;
        bit v;
        bit sy;
        bus.sValid  = 1'b0;
        bus.data_pt = '0;
        bus.sync    = 1'b0;
        bus.rEN     = 1'b0;
        model_reset();
        #1;
        chk("por_dOut",     bus.dOut,     0);
        chk("por_bEmpty",   bus.bEmpty,   1);
        chk("por_bFull",    bus.bFull,    0);
        chk("por_overflow", bus.overflow, 0);
        @(posedge CLK);
        #1;
        RESET  = 1'b1;
        chk_en = 1'b1;

        // Samples before any sync are ignored
        for (int i = 0; i < 10; i++) step(1'b1, 30000, 1'b0, 1'b0);

        // Alternating +/-16000 -> 1, then +100 -> 0
        group(16000, 1'b1, 1'b0);
        for (int i = 0; i < SPB; i++) step(1'b1, 100, 1'b0, 1'b0);
        pops(2);
        idle(2);

        // Full-scale negative, then exactly-at-threshold group
        step(1'b1, -32768, 1'b1, 1'b0);
        for (int i = 1; i < SPB; i++) step(1'b1, -32768, 1'b0, 1'b0);
        for (int i = 0; i < SPB; i++) step(1'b1, 8192, 1'b0, 1'b0);
        pops(2);
        idle(2);

        // Fill, overflow on 9th, drain in order, pop while empty
        pat = 8'b1011_0010;
        for (int g = 0; g < 9; g++) group(pat[g % 8] ? 20000 : 1000, g == 0, 1'b0);
        idle(2);
        pops(9);
        idle(2);

        do_reset("rst_ovf");

        // Full FIFO with 9th decision coinciding with a pop
        pat = 8'b0110_1101;
        for (int g = 0; g < 8; g++) group(pat[g] ? 20000 : 1000, g == 0, 1'b0);
        group(20000, 1'b0, 1'b1);
        idle(2);
        pops(2);
        for (int i = 0; i < 3; i++) step(1'b1, 20000, 1'b0, 1'b0);
        do_reset("rst_mid");

        // After reset the receiver waits for sync again
        for (int i = 0; i < 12; i++) step(1'b1, 20000, 1'b0, 1'b1);

        // Restart on sync discards a partial group; gaps hold the accumulator
        for (int i = 0; i < 5; i++) step(1'b1, 16000, i == 0, 1'b0);
        for (int i = 0; i < SPB; i++) begin
            step(1'b1, 16000, i == 0, 1'b0);
            if (i % 3 == 1) idle(2);
        end
        idle(3);
        pops(2);

        // Random traffic
        amp = 10000;
        for (int i = 0; i < 3000; i++) begin
            v  = ($urandom % 4) != 0;
            sy = (i == 0) || (v && ($urandom % 60) == 0);
            if (($urandom % 8) == 0) amp = $urandom_range(0, 20000);
            s = (($urandom % 2) != 0) ? -amp : amp;
            if (($urandom % 200) == 0) s = -32768;
            step(v || (i == 0), s, sy, ($urandom % 3) == 0);
        end
        pops(DEPTH + 2);
        idle(3);

        chk("rdy_queue_drained",  exp_rdy_q.size(),  0);
        chk("dout_queue_drained", exp_dout_q.size(), 0);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
